// File: rtl/debounce_multi.sv
// ============================================================================
// Module   : debounce_multi
// Purpose  : N-channel push-button/switch debouncer with a synchroniser,
//            stable-time filter, rise/fall strobes and an optional
//            long-press strobe (enabled by macro DEBOUNCE_MULTI_HOLD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_multi #(
  parameter int N_CH        = 4,
  parameter int DB_COUNT    = 2_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_COUNT  = 100_000_000,
  parameter int CNT_W       = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_input,
  output logic [N_CH-1:0] o_db,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_hold
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  localparam int             MAX_CNT   = (DB_COUNT > HOLD_COUNT) ? DB_COUNT : HOLD_COUNT;
  localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DB_COUNT - 1);

  // Configuration sanity checks; these branches are never elaborated for legal settings.
  if (N_CH < 1 || SYNC_STAGES < 2 || DB_COUNT < 1 || HOLD_COUNT < 1) begin : g_bad_param
    $fatal(1, "debounce_multi: illegal parameter value");
  end
  if (CNT_W < $clog2(MAX_CNT + 1)) begin : g_bad_cnt_w
    $fatal(1, "debounce_multi: CNT_W too small for DB_COUNT/HOLD_COUNT");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s      = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], i_input[i]};

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sync_q  <= '0;
        state_q <= S_IDLE;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_IDLE:  if (s != db_q) state_d = S_COUNT;
        S_COUNT: if (s == db_q || cnt_q == C_DB_LAST) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // The counter only runs while in COUNT with the mismatch persisting;
    // every other path (idle, glitch, update) returns it to zero.
    always_comb begin
      cnt_d  = '0;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (state_q == S_COUNT && s != db_q) begin
        if (cnt_q == C_DB_LAST) begin
          db_d   = s;
          rise_d = s;
          fall_d = ~s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign o_db[i]   = db_q;
    assign o_rise[i] = rise_q;
    assign o_fall[i] = fall_q;

`ifdef DEBOUNCE_MULTI_HOLD_EN
    localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD_COUNT);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hold_q, hold_d;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        hold_cnt_q <= '0;
        hold_q     <= 1'b0;
      end else begin
        hold_cnt_q <= hold_cnt_d;
        hold_q     <= hold_d;
      end
    end

    // Saturating at C_HOLD guarantees a single strobe per press.
    always_comb begin
      hold_cnt_d = '0;
      hold_d     = 1'b0;
      if (db_q) begin
        hold_cnt_d = (hold_cnt_q == C_HOLD) ? hold_cnt_q : hold_cnt_q + 1'b1;
        hold_d     = (hold_cnt_q == C_HOLD - 1'b1);
      end
    end

    assign o_hold[i] = hold_q;
`else
    assign o_hold[i] = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_debounce_multi.sv
// ============================================================================
// Module   : tb_debounce_multi
// Purpose  : Directed, scoreboard-checked bench for debounce_multi
//            (N_CH=4, DB_COUNT=4, SYNC_STAGES=2, HOLD_COUNT=10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [3:0] o_db, o_rise, o_fall, o_hold;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];

  debounce_multi #(
    .N_CH       (4),
    .DB_COUNT   (4),
    .SYNC_STAGES(2),
    .HOLD_COUNT (10),
    .CNT_W      (32)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_input(din),
    .o_db   (o_db),
    .o_rise (o_rise),
    .o_fall (o_fall),
    .o_hold (o_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [3:0] hx(input logic [3:0] v);
`ifdef DEBOUNCE_MULTI_HOLD_EN
    return v;
`else
    return 4'h0;
`endif
  endfunction

  task automatic push(input int c, input string tag, input logic [3:0] db,
                      input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] hold);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.v   = {db, rise, fall, hold};
    sb.push_back(e);
  endtask

  task automatic wait_to(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  // Outputs only move on posedge, so the negedge is a stable sampling point.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [15:0] obs;
      e   = sb.pop_front();
      obs = {o_db, o_rise, o_fall, o_hold};
      n_cmp++;
      assert (e.cyc == cyc && obs === e.v) else begin
        n_bad++;
        $error("FAIL %s cyc=%0d (due %0d) db/rise/fall/hold observed=%h expected=%h",
               e.tag, cyc, e.cyc, obs, e.v);
      end
    end
  end

  initial begin
    int r, c, g;
    rst = 1'b1;
    din = 4'hF;

    // Reset held with inputs high: everything stays zero.
    for (int k = 1; k <= 4; k++) push(k, "reset_hold", 4'h0, 4'h0, 4'h0, 4'h0);
    wait_to(4);
    rst = 1'b0;
    r   = cyc;
    for (int k = 1; k <= 6; k++) push(r + k, "release_quiet", 4'h0, 4'h0, 4'h0, 4'h0);
    push(r + 7, "release_rise", 4'hF, 4'hF, 4'h0, 4'h0);
    for (int k = 8; k <= 25; k++)
      push(r + k, "release_held", 4'hF, 4'h0, 4'h0, (k == 17) ? hx(4'hF) : 4'h0);
    wait_to(r + 26);

    // Single-channel fall on ch2.
    c   = cyc;
    din = 4'hB;
    for (int k = 1; k <= 6; k++) push(c + k, "fall2_wait", 4'hF, 4'h0, 4'h0, 4'h0);
    push(c + 7, "fall2_edge", 4'hB, 4'h0, 4'h4, 4'h0);
    push(c + 8, "fall2_after", 4'hB, 4'h0, 4'h0, 4'h0);
    wait_to(c + 9);

    // Remaining channels fall together.
    c   = cyc;
    din = 4'h0;
    for (int k = 1; k <= 6; k++) push(c + k, "fall_all_wait", 4'hB, 4'h0, 4'h0, 4'h0);
    push(c + 7, "fall_all_edge", 4'h0, 4'h0, 4'hB, 4'h0);
    push(c + 8, "fall_all_after", 4'h0, 4'h0, 4'h0, 4'h0);
    wait_to(c + 9);

    // Glitch train on ch0 (3 high / 1 low) must never reach the output.
    c = cyc;
    for (int k = 1; k <= 106; k++) push(c + k, "glitch_quiet", 4'h0, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 100; k++) begin
      din[0] = (k % 4) != 3;
      @(negedge clk);
    end
    // Then a short press: five input cycles high, five cycles of o_db high, no hold.
    g      = cyc;
    din[0] = 1'b1;
    push(g + 7, "short_rise", 4'h1, 4'h1, 4'h0, 4'h0);
    for (int k = 8; k <= 11; k++) push(g + k, "short_high", 4'h1, 4'h0, 4'h0, 4'h0);
    push(g + 12, "short_fall", 4'h0, 4'h0, 4'h1, 4'h0);
    for (int k = 13; k <= 25; k++) push(g + k, "short_nohold", 4'h0, 4'h0, 4'h0, 4'h0);
    wait_to(g + 5);
    din[0] = 1'b0;
    wait_to(g + 26);

    // Simultaneous rise on ch1 and ch3, held long enough to see one hold strobe.
    c   = cyc;
    din = 4'hA;
    for (int k = 1; k <= 6; k++) push(c + k, "simul_wait", 4'h0, 4'h0, 4'h0, 4'h0);
    push(c + 7, "simul_rise", 4'hA, 4'hA, 4'h0, 4'h0);
    for (int k = 8; k <= 25; k++)
      push(c + k, "simul_held", 4'hA, 4'h0, 4'h0, (k == 17) ? hx(4'hA) : 4'h0);
    wait_to(c + 26);

    // Raise ch0, then reset mid-count: all state discarded, restart after release.
    c   = cyc;
    din = 4'hB;
    for (int k = 1; k <= 3; k++) push(c + k, "midrst_pre", 4'hA, 4'h0, 4'h0, 4'h0);
    for (int k = 4; k <= 10; k++) push(c + k, "midrst_quiet", 4'h0, 4'h0, 4'h0, 4'h0);
    push(c + 11, "midrst_rise", 4'hB, 4'hB, 4'h0, 4'h0);
    for (int k = 12; k <= 25; k++)
      push(c + k, "midrst_held", 4'hB, 4'h0, 4'h0, (k == 21) ? hx(4'hB) : 4'h0);
    wait_to(c + 3);
    rst = 1'b1;
    wait_to(c + 4);
    rst = 1'b0;
    wait_to(c + 28);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
